// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: control bundle, operands and register addresses
// with stall (hold), flush (bubble) and a registered valid bit.
//
// Ports:
//   clk_i, rst_i (async, active-low), stall_i, flush_i, valid_i
//   ctrl_i[CW], rs/rt_data_i[DW], imm_i[DW], rs/rt/rd_addr_i[AW]
//   valid_o, ctrl_o, rs/rt_data_o, imm_o, rs/rt/rd_addr_o
//   regwrite_o, memread_o : ctrl_o bits gated by valid_o
// Optional (macro IDEX_BUBBLE_CNT_EN): bubble_cnt_o[32], saturating count
//   of edges where a bubble enters the register.
module id_ex_reg #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 9
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          valid_i,
   input  logic [CW-1:0] ctrl_i,
   input  logic [DW-1:0] rs_data_i,
   input  logic [DW-1:0] rt_data_i,
   input  logic [DW-1:0] imm_i,
   input  logic [AW-1:0] rs_addr_i,
   input  logic [AW-1:0] rt_addr_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic          valid_o,
   output logic [CW-1:0] ctrl_o,
   output logic [DW-1:0] rs_data_o,
   output logic [DW-1:0] rt_data_o,
   output logic [DW-1:0] imm_o,
   output logic [AW-1:0] rs_addr_o,
   output logic [AW-1:0] rt_addr_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          regwrite_o,
   output logic          memread_o
`ifdef IDEX_BUBBLE_CNT_EN
   ,
   output logic [31:0]   bubble_cnt_o
`endif
);

   localparam int REGWRITE_BIT = 8;
   localparam int MEMREAD_BIT  = 6;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          load;
   logic [CW-1:0] ctrl_q;
   logic [DW-1:0] rs_data_q;
   logic [DW-1:0] rt_data_q;
   logic [DW-1:0] imm_q;
   logic [AW-1:0] rs_addr_q;
   logic [AW-1:0] rt_addr_q;
   logic [AW-1:0] rd_addr_q;

   // flush beats stall beats load
   assign load = !flush_i && !stall_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = EMPTY;
      end else if (load) begin
         state_d = valid_i ? FULL : EMPTY;
      end
   end

   always_comb begin
      valid_o    = (state_q == FULL);
      regwrite_o = ctrl_q[REGWRITE_BIT] && valid_o;
      memread_o  = ctrl_q[MEMREAD_BIT] && valid_o;
   end

   // bubbles are fully zeroed so nothing stale leaks into forwarding
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
      end else if (flush_i) begin
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
      end else if (load) begin
         ctrl_q    <= valid_i ? ctrl_i : '0;
         rs_data_q <= rs_data_i;
         rt_data_q <= rt_data_i;
         imm_q     <= imm_i;
         rs_addr_q <= rs_addr_i;
         rt_addr_q <= rt_addr_i;
         rd_addr_q <= rd_addr_i;
      end
   end

   assign ctrl_o    = ctrl_q;
   assign rs_data_o = rs_data_q;
   assign rt_data_o = rt_data_q;
   assign imm_o     = imm_q;
   assign rs_addr_o = rs_addr_q;
   assign rt_addr_o = rt_addr_q;
   assign rd_addr_o = rd_addr_q;

`ifdef IDEX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic        bubble_in;

   assign bubble_in = flush_i || (load && !valid_i);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_q <= '0;
      end else if (bubble_in && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: randomized and directed stimulus,
// expected state from a rule-level model, checked by a separate monitor.
module tb_id_ex_reg;

   typedef struct packed {
      logic        v;
      logic [8:0]  c;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] im;
      logic [4:0]  ra;
      logic [4:0]  ta;
      logic [4:0]  da;
      logic        rw;
      logic        mr;
      logic [31:0] bc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [8:0]  ctrl_i = '0;
   logic [31:0] rs_data_i = '0;
   logic [31:0] rt_data_i = '0;
   logic [31:0] imm_i = '0;
   logic [4:0]  rs_addr_i = '0;
   logic [4:0]  rt_addr_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        valid_o;
   logic [8:0]  ctrl_o;
   logic [31:0] rs_data_o;
   logic [31:0] rt_data_o;
   logic [31:0] imm_o;
   logic [4:0]  rs_addr_o;
   logic [4:0]  rt_addr_o;
   logic [4:0]  rd_addr_o;
   logic        regwrite_o;
   logic        memread_o;
`ifdef IDEX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_o;
`endif

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t model = '0;
   exp_t sb_q[$];

   id_ex_reg dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .valid_i    (valid_i),
      .ctrl_i     (ctrl_i),
      .rs_data_i  (rs_data_i),
      .rt_data_i  (rt_data_i),
      .imm_i      (imm_i),
      .rs_addr_i  (rs_addr_i),
      .rt_addr_i  (rt_addr_i),
      .rd_addr_i  (rd_addr_i),
      .valid_o    (valid_o),
      .ctrl_o     (ctrl_o),
      .rs_data_o  (rs_data_o),
      .rt_data_o  (rt_data_o),
      .imm_o      (imm_o),
      .rs_addr_o  (rs_addr_o),
      .rt_addr_o  (rt_addr_o),
      .rd_addr_o  (rd_addr_o),
      .regwrite_o (regwrite_o),
      .memread_o  (memread_o)
`ifdef IDEX_BUBBLE_CNT_EN
      ,
      .bubble_cnt_o (bubble_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t sample();
      exp_t a;
      a.v  = valid_o;
      a.c  = ctrl_o;
      a.rs = rs_data_o;
      a.rt = rt_data_o;
      a.im = imm_o;
      a.ra = rs_addr_o;
      a.ta = rt_addr_o;
      a.da = rd_addr_o;
      a.rw = regwrite_o;
      a.mr = memread_o;
`ifdef IDEX_BUBBLE_CNT_EN
      a.bc = bubble_cnt_o;
`else
      a.bc = '0;
`endif
      return a;
   endfunction

   function automatic exp_t strip(input exp_t e);
      exp_t r;
      r = e;
`ifndef IDEX_BUBBLE_CNT_EN
      r.bc = '0;
`endif
      return r;
   endfunction

   task automatic chk(input string nm, input logic [159:0] act,
                      input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic st, input logic v,
                        input logic [8:0] c, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] im,
                        input logic [4:0] ra, input logic [4:0] ta,
                        input logic [4:0] da);
      logic bub;
      @(negedge clk);
      flush_i   = fl;
      stall_i   = st;
      valid_i   = v;
      ctrl_i    = c;
      rs_data_i = rs;
      rt_data_i = rt;
      imm_i     = im;
      rs_addr_i = ra;
      rt_addr_i = ta;
      rd_addr_i = da;
      bub = fl || (!st && !v);
      if (fl) begin
         model.v  = 1'b0;
         model.c  = '0;
         model.rs = '0;
         model.rt = '0;
         model.im = '0;
         model.ra = '0;
         model.ta = '0;
         model.da = '0;
      end else if (!st) begin
         model.v  = v;
         model.c  = v ? c : 9'h000;
         model.rs = rs;
         model.rt = rt;
         model.im = im;
         model.ra = ra;
         model.ta = ta;
         model.da = da;
      end
      model.rw = model.v && model.c[8];
      model.mr = model.v && model.c[6];
      if (bub && model.bc != 32'hFFFF_FFFF) model.bc = model.bc + 1;
      sb_q.push_back(strip(model));
   endtask

   task automatic rnd_drive(input logic fl, input logic st, input logic v,
                            input logic [8:0] c);
      drive(fl, st, v, c, $urandom(), $urandom(), $urandom(),
            5'($urandom_range(31)), 5'($urandom_range(31)),
            5'($urandom_range(31)));
   endtask

   // monitor: the register presents new contents once per rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_state", 160'(sample()), 160'(e));
         end
      end
   end

   initial begin
      #3;
      chk("reset_state", 160'(sample()), 160'(exp_t'('0)));
      @(negedge clk);
      @(negedge clk);
      stall_i = 1'b1;
      rst_i = 1'b1;

      drive(0, 0, 1, 9'b100001101, 32'h5, 32'h9, 32'h20, 5'd1, 5'd2, 5'd3);
      @(posedge clk);
      #2;
      chk("rtype_ctrl", 160'(ctrl_o), 160'(9'h10D));
      chk("rtype_rs", 160'({rs_data_o, rd_addr_o, regwrite_o, memread_o}),
          160'({32'h5, 5'd3, 1'b1, 1'b0}));

      drive(0, 0, 1, 9'b111000010, 32'h100, 32'h7, 32'h4, 5'd4, 5'd5, 5'd6);
      for (int i = 0; i < 3; i++) rnd_drive(0, 1, 1, 9'($urandom()));
      @(posedge clk);
      #2;
      chk("stall_hold", 160'({memread_o, ctrl_o, rs_data_o, rt_addr_o}),
          160'({1'b1, 9'h1C2, 32'h100, 5'd5}));

      rnd_drive(1, 1, 1, 9'h1FF);
      @(posedge clk);
      #2;
      chk("flush_stall", 160'(sample()), 160'(exp_t'('0)));

      drive(0, 0, 0, 9'h1FF, 32'h1, 32'hCAFE_F00D, 32'h2, 5'd7, 5'd8, 5'd9);
      @(posedge clk);
      #2;
      chk("invalid_load", 160'({valid_o, ctrl_o, rt_data_o}),
          160'({1'b0, 9'h000, 32'hCAFE_F00D}));

      drive(0, 0, 1, 9'h1FF, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3);
      @(posedge clk);
      #3;
      rst_i = 1'b0;
      #1;
      chk("async_reset", 160'(sample()), 160'(exp_t'('0)));
      @(posedge clk);
      #1;
      chk("reset_hold", 160'(sample()), 160'(exp_t'('0)));
      @(negedge clk);
      stall_i = 1'b1;
      flush_i = 1'b0;
      rst_i = 1'b1;
      model = '0;

      drive(0, 0, 1, 9'h140, 32'hA, 32'hB, 32'hC, 5'd10, 5'd11, 5'd12);

`ifdef IDEX_BUBBLE_CNT_EN
      rnd_drive(1, 0, 1, 9'h1FF);
      rnd_drive(1, 1, 1, 9'h1FF);
      rnd_drive(0, 0, 0, 9'h1FF);
      for (int i = 0; i < 4; i++) rnd_drive(0, 1, 0, 9'h1FF);
      @(posedge clk);
      #2;
      chk("bubble_cnt", 160'(bubble_cnt_o), 160'(32'd3));
`endif

      for (int i = 0; i < 400; i++) begin
         rnd_drive(($urandom_range(7) == 0), ($urandom_range(3) == 0),
                   ($urandom_range(3) != 0), 9'($urandom()));
      end

      repeat (3) @(posedge clk);
      #2;
      chk("sb_drained", 160'(sb_q.size()), 160'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
